// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan peripheral: register offsets, FCR/FSR bit
// positions, active-low seven-segment codes and the APB handshake states.
package fnd_pkg;

    localparam logic [3:0] FCR_OFFSET = 4'h0;
    localparam logic [3:0] FDR_OFFSET = 4'h4;
    localparam logic [3:0] FPR_OFFSET = 4'h8;
    localparam logic [3:0] FSR_OFFSET = 4'hC;

    localparam int unsigned FCR_EN_BIT    = 0;
    localparam int unsigned FCR_BLINK_BIT = 1;
    localparam int unsigned FCR_MASK_LSB  = 8;
    localparam int unsigned FSR_PHASE_BIT = 8;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] FND_BLANK = 8'hFF;

    typedef enum logic {
        APB_IDLE,
        APB_ACK
    } apb_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        case (hex)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/fnd_scan_periph_if.sv
// APB bus bundle between the system bus and the FND peripheral.
interface fnd_scan_periph_if;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/fnd_scanner.sv
// Digit scan engine: prescaler, digit index, frame/blink counters and the
// registered active-low common/segment drivers.
module fnd_scanner
    import fnd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 64
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          en,
    input  logic                          blink_en,
    input  logic [NUM_DIGITS-1:0]         digit_mask,
    input  logic [4*NUM_DIGITS-1:0]       digit_data,
    input  logic [NUM_DIGITS-1:0]         digit_dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          blink_phase,
    output logic [NUM_DIGITS-1:0]         fndComm,
    output logic [7:0]                    fndFont
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0]         psc;
    logic [FW-1:0]         frm;
    logic                  lit;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] comm_next;
    logic [7:0]            font_next;

    // Disabling parks every counter so re-enable starts a fresh digit-0 dwell.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            psc         <= '0;
            digit_idx   <= '0;
            frm         <= '0;
            blink_phase <= 1'b1;
        end else if (!en) begin
            psc         <= '0;
            digit_idx   <= '0;
            frm         <= '0;
            blink_phase <= 1'b1;
        end else if (psc == PSC_LAST) begin
            psc <= '0;
            if (digit_idx == IDX_LAST) begin
                digit_idx <= '0;
                if (frm == FRM_LAST) begin
                    frm         <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frm <= frm + 1'b1;
                end
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            psc <= psc + 1'b1;
        end
    end

    always_comb begin
        comm_next = '1;
        font_next = FND_BLANK;
        nibble    = digit_data[{digit_idx, 2'b00} +: 4];
        lit       = en & digit_mask[digit_idx] & (blink_phase | ~blink_en);
        if (lit) begin
            comm_next[digit_idx] = 1'b0;
            font_next            = hex_to_seg(nibble);
            if (digit_dp[digit_idx]) begin
                font_next[7] = 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            fndComm <= '1;
            fndFont <= FND_BLANK;
        end else begin
            fndComm <= comm_next;
            fndFont <= font_next;
        end
    end

endmodule

// File: rtl/fnd_scan_periph.sv
// APB FND peripheral: register file with a one-wait-state handshake, driving
// the digit scanner that feeds the board's common/segment pins.
module fnd_scan_periph
    import fnd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLINK_DIV  = 64
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    fnd_scan_periph_if.slave      apb,
    output logic [NUM_DIGITS-1:0] fndComm,
    output logic [7:0]            fndFont
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);

    apb_state_t state, state_next;

    logic                    access;
    logic                    en;
    logic                    blink_en;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] fdr;
    logic [NUM_DIGITS-1:0]   fpr;
    logic [IW-1:0]           digit_idx;
    logic                    blink_phase;
    logic [31:0]             rd_data;

    // PREADY masks the access term so each transfer commits exactly once.
    assign access     = apb.PSEL & apb.PENABLE & ~apb.PREADY;
    assign apb.PREADY = (state == APB_ACK);

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state <= APB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = APB_IDLE;
        case (state)
            APB_IDLE: if (access) state_next = APB_ACK;
            APB_ACK:  state_next = APB_IDLE;
            default:  state_next = APB_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (apb.PADDR[3:2])
            FCR_OFFSET[3:2]: begin
                rd_data[FCR_EN_BIT]                   = en;
                rd_data[FCR_BLINK_BIT]                = blink_en;
                rd_data[FCR_MASK_LSB +: NUM_DIGITS]   = mask;
            end
            FDR_OFFSET[3:2]: rd_data[4*NUM_DIGITS-1:0] = fdr;
            FPR_OFFSET[3:2]: rd_data[NUM_DIGITS-1:0]   = fpr;
            default: begin
                rd_data[IW-1:0]          = digit_idx;
                rd_data[FSR_PHASE_BIT]   = blink_phase;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en         <= 1'b0;
            blink_en   <= 1'b0;
            mask       <= '0;
            fdr        <= '0;
            fpr        <= '0;
            apb.PRDATA <= '0;
        end else if (access) begin
            if (apb.PWRITE) begin
                case (apb.PADDR[3:2])
                    FCR_OFFSET[3:2]: begin
                        en       <= apb.PWDATA[FCR_EN_BIT];
                        blink_en <= apb.PWDATA[FCR_BLINK_BIT];
                        mask     <= apb.PWDATA[FCR_MASK_LSB +: NUM_DIGITS];
                    end
                    FDR_OFFSET[3:2]: fdr <= apb.PWDATA[4*NUM_DIGITS-1:0];
                    FPR_OFFSET[3:2]: fpr <= apb.PWDATA[NUM_DIGITS-1:0];
                    default: ;
                endcase
            end else begin
                apb.PRDATA <= rd_data;
            end
        end
    end

    fnd_scanner #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) u_scanner (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .en          (en),
        .blink_en    (blink_en),
        .digit_mask  (mask),
        .digit_data  (fdr),
        .digit_dp    (fpr),
        .digit_idx   (digit_idx),
        .blink_phase (blink_phase),
        .fndComm     (fndComm),
        .fndFont     (fndFont)
    );

endmodule

// File: tb/tb_fnd_scan_periph.sv
// Bench for fnd_scan_periph: APB register traffic plus a time-based model of
// the scanned display, checked every cycle.
module tb_fnd_scan_periph;

    localparam int unsigned N  = 4;
    localparam int unsigned SD = 4;
    localparam int unsigned BD = 2;

    logic         PCLK   = 1'b0;
    logic         PRESET = 1'b0;
    logic [N-1:0] fndComm;
    logic [7:0]   fndFont;

    fnd_scan_periph_if bus ();

    fnd_scan_periph #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLINK_DIV  (BD)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (bus.slave),
        .fndComm (fndComm),
        .fndFont (fndFont)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Committed register contents (m_*) and the values seen by the previous edge (p_*).
    logic [31:0] m_fcr = '0, m_fdr = '0, m_fpr = '0;
    logic [31:0] p_fcr = '0, p_fdr = '0, p_fpr = '0;
    int          p_s   = 0;   // enabled cycles elapsed since scanning (re)started
    bit          mon_on = 1'b0;

    function automatic int digit_of(input int s);
        return (s / SD) % N;
    endfunction

    function automatic bit phase_of(input int s);
        return ((s / (SD * N)) / BD) % 2 == 0;
    endfunction

    task automatic exp_disp(input logic [31:0] fcr, input logic [31:0] fdr, input logic [31:0] fpr,
                            input int s, output logic [N-1:0] comm, output logic [7:0] font);
        int d;
        logic [3:0] nib;
        d    = digit_of(s);
        comm = '1;
        font = 8'hFF;
        if (fcr[0] && fcr[8 + d] && (phase_of(s) || !fcr[1])) begin
            comm[d] = 1'b0;
            nib     = fdr[4*d +: 4];
            font    = seg_tab[nib];
            if (fpr[d]) font[7] = 1'b0;
        end
    endtask

    always @(negedge PCLK) begin
        logic [N-1:0] ec;
        logic [7:0]   ef;
        if (mon_on) begin
            if (!PRESET) begin
                check_eq("comm_rst", 32'(fndComm), 32'(4'hF));
                check_eq("font_rst", 32'(fndFont), 32'h0000_00FF);
                p_fcr = '0; p_fdr = '0; p_fpr = '0; p_s = 0;
            end else begin
                exp_disp(p_fcr, p_fdr, p_fpr, p_s, ec, ef);
                check_eq("comm", 32'(fndComm), 32'(ec));
                check_eq("font", 32'(fndFont), 32'(ef));
                p_s   = p_fcr[0] ? p_s + 1 : 0;
                p_fcr = m_fcr;
                p_fdr = m_fdr;
                p_fpr = m_fpr;
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        check_eq("pready_lo", 32'(bus.PREADY), 32'd0);
        @(posedge PCLK); #1;
        check_eq("pready_hi", 32'(bus.PREADY), 32'd1);
        rdata       = bus.PRDATA;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, wdata, dummy);
        case (addr)
            4'h0:    m_fcr = wdata & 32'h0000_0F03;
            4'h4:    m_fdr = wdata & 32'h0000_FFFF;
            4'h8:    m_fpr = wdata & 32'h0000_000F;
            default: ;
        endcase
    endtask

    task automatic apb_read(input logic [3:0] addr);
        logic [31:0] got, exp;
        apb_xfer(1'b0, addr, $urandom, got);
        case (addr)
            4'h0:    exp = m_fcr;
            4'h4:    exp = m_fdr;
            4'h8:    exp = m_fpr;
            default: exp = (phase_of(p_s) ? 32'h100 : 32'h0) | 32'(digit_of(p_s));
        endcase
        check_eq($sformatf("rd_%h", addr), got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int r;
        logic [3:0]  a;
        logic [31:0] d;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0;
        mon_on = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("comm_init", 32'(fndComm), 32'(4'hF));
        check_eq("font_init", 32'(fndFont), 32'h0000_00FF);
        check_eq("pready_init", 32'(bus.PREADY), 32'd0);
        check_eq("prdata_init", bus.PRDATA, 32'd0);
        PRESET = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) apb_read(4'(4 * i));

        apb_write(4'h4, 32'h0000_4321);
        apb_write(4'h0, 32'h0000_0F01);
        idle(40);
        apb_write(4'h8, 32'h1);
        idle(20);
        apb_write(4'h0, 32'h0000_0501);
        idle(20);
        apb_write(4'h0, 32'h0000_0F03);
        for (int i = 0; i < 8; i++) begin
            idle(9);
            apb_read(4'hC);
        end
        apb_write(4'hC, 32'hFFFF_FFFF);
        apb_read(4'hC);
        apb_read(4'h0);
        idle(7);
        apb_write(4'h0, 32'h0000_0F00);
        idle(5);
        apb_read(4'hC);
        apb_write(4'h0, 32'h0000_0F01);
        apb_read(4'hC);
        idle(12);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom_range(0, 3) * 4);
            if (r < 6) begin
                d = $urandom;
                if (a == 4'h0) d[0] = ($urandom_range(0, 3) != 0);
                apb_write(a, d);
            end else begin
                apb_read(a);
            end
            idle($urandom_range(0, 30));
        end

        apb_write(4'h0, 32'h0000_0F01);
        apb_write(4'h4, $urandom);
        for (k = 0; k < 200; k++) begin
            if ((p_s % (SD * N)) == 2 * SD + 2) break;
            idle(1);
        end
        check_eq("wait_dig2", 32'(k < 200), 32'd1);
        #1;
        PRESET = 1'b0;
        m_fcr = '0; m_fdr = '0; m_fpr = '0;
        #1;
        check_eq("comm_async", 32'(fndComm), 32'(4'hF));
        check_eq("font_async", 32'(fndFont), 32'h0000_00FF);
        check_eq("prdata_async", bus.PRDATA, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) apb_read(4'(4 * i));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
